control_edicion_campos: RTL and testbench
=========================================

Name: control_edicion_campos

Overview:
- Sequences manual time/date setting for the field counters (day, month, year, hours, ...).
- Turns debounced button levels into a field-select code (contadoresH), single-cycle Arriba/Abajo step pulses with hold-to-repeat, and a write-request handshake toward the RTC write engine when editing ends.
- Sits between the button debouncers and the bank of field counters. Only the counter whose index matches contadoresH responds.

Parameters:
- NUM_CAMPOS, 9, number of editable fields; valid field indices are 1..NUM_CAMPOS; 0 means no field selected.
- T_RETARDO, 50000000, clk cycles a step button must be held before auto-repeat starts (500 ms at 100 MHz).
- T_REPETIR, 25000000, clk cycles between repeated step pulses (~4 Hz at 100 MHz).
- T_ACK_MAX, 1000000, clk cycles to wait for wr_ack before aborting the commit.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- btn_prog  in  1  debounced, synchronous level; toggles edit mode
- btn_izq  in  1  debounced level; select previous field
- btn_der  in  1  debounced level; select next field
- btn_arr  in  1  debounced level; increment the selected field
- btn_abj  in  1  debounced level; decrement the selected field
- wr_ack  in  1  one-cycle pulse from the RTC writer; commit accepted
- contadoresH  out  4  selected field index; 0 when not editing
- Arriba  out  1  one-cycle increment pulse
- Abajo  out  1  one-cycle decrement pulse
- en_prog  out  1  high while in EDICION or REPITE
- wr_req  out  1  level; held high until wr_ack or timeout
- err_ack  out  1  one-cycle pulse on commit timeout

Behaviour:
- Reset values, asynchronous: state=REPOSO, contadoresH=0, Arriba=0, Abajo=0, en_prog=0, wr_req=0, err_ack=0, all timers and edge registers=0.
- Edge detection: each button has a one-cycle registered copy. A press is level=1 with previous=0. Edges are ignored on the cycle reset deasserts.
- Outputs are registered. A pulse appears 1 cycle after the edge cycle.
- States:
  - REPOSO: a btn_prog edge goes to EDICION with contadoresH=1. All other buttons are ignored.
  - EDICION:
    - btn_der edge: contadoresH+1; NUM_CAMPOS wraps to 1.
    - btn_izq edge: contadoresH-1; 1 wraps to NUM_CAMPOS.
    - btn_arr edge: one Arriba pulse, load timer=T_RETARDO, go to REPITE.
    - btn_abj edge: one Abajo pulse, same timer load, go to REPITE.
    - btn_prog edge: go to ESCRITURA.
  - REPITE:
    - Timer decrements each cycle while the originating button is still held.
    - When the timer reaches 0: emit one more pulse of the same direction and reload T_REPETIR.
    - Release of the originating button returns to EDICION with no extra pulse.
    - Pressing the opposite step button, izq/der or prog while in REPITE: ignored until return to EDICION.
  - ESCRITURA:
    - On entry: wr_req=1, en_prog=0, contadoresH=0, timer=T_ACK_MAX.
    - wr_ack: wr_req=0 on the next cycle, go to REPOSO.
    - Timer expiry: wr_req=0, err_ack pulse, go to REPOSO.
    - wr_ack arriving outside ESCRITURA is ignored.
- Priority when several edges occur in the same EDICION cycle: prog > der > izq > arr > abj. btn_arr and btn_abj edges in the same cycle produce no pulse and no state change.
- Arriba and Abajo are never high together and are never asserted while contadoresH=0.
- Timers: width is clog2 of the largest parameter. No overflow is possible, because they only load and decrement to 0.
- Reset asserted mid-repeat or mid-commit: immediate return to reset values. No pulse and no wr_req are emitted afterwards.

Test Plan:
- Sim parameters: T_RETARDO=8, T_REPETIR=4, T_ACK_MAX=6, NUM_CAMPOS=9.
- Enter/select: reset, press btn_prog -> en_prog=1, contadoresH=1. Press btn_izq -> 9. Press btn_der twice -> 2.
- Single step: in field 6, btn_arr high for 3 cycles -> exactly one Arriba pulse, 1 cycle after the edge. Abajo stays 0.
- Auto-repeat: btn_abj held 20 cycles -> Abajo pulses at edge+1, then after 8 cycles, then every 4 cycles (4 pulses total). On release: no further pulses, state EDICION.
- Conflict: btn_arr and btn_abj rise in the same cycle -> no pulse. btn_der and btn_arr rise together -> contadoresH increments, no Arriba.
- Commit: btn_prog in EDICION -> contadoresH=0, wr_req=1. wr_ack after 3 cycles -> wr_req=0, state REPOSO. Repeat with no ack -> err_ack pulse after 6 cycles, wr_req=0.
- Reset mid-operation: assert reset during REPITE and during ESCRITURA -> all outputs 0 in the same cycle. After release, held buttons produce no pulses until re-pressed.

Source files
------------

// File: rtl/control_edicion_campos_if.sv
`default_nettype none
// ============================================================================
// Module      : control_edicion_campos_if
// Description : Button levels in, field-select / step / write-request out.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_edicion_campos_if;
    logic       btn_prog;
    logic       btn_izq;
    logic       btn_der;
    logic       btn_arr;
    logic       btn_abj;
    logic       wr_ack;
    logic [3:0] contadoresH;
    logic       Arriba;
    logic       Abajo;
    logic       en_prog;
    logic       wr_req;
    logic       err_ack;

    modport master (
        output btn_prog, btn_izq, btn_der, btn_arr, btn_abj, wr_ack,
        input  contadoresH, Arriba, Abajo, en_prog, wr_req, err_ack
    );

    modport slave (
        input  btn_prog, btn_izq, btn_der, btn_arr, btn_abj, wr_ack,
        output contadoresH, Arriba, Abajo, en_prog, wr_req, err_ack
    );
endinterface
`default_nettype wire

// File: rtl/control_edicion_campos.sv
`default_nettype none
// ============================================================================
// Module      : control_edicion_campos
// Description : Edit-mode sequencer for manual time/date field setting.
// Revision    : 1.0 - initial release
// ============================================================================
module control_edicion_campos #(
    parameter int NUM_CAMPOS = 9,
    parameter int T_RETARDO  = 50000000,
    parameter int T_REPETIR  = 25000000,
    parameter int T_ACK_MAX  = 1000000
) (
    input  wire logic                clk,
    input  wire logic                reset,
    control_edicion_campos_if.slave  bus
);

    localparam int T_MAX_A = (T_RETARDO > T_REPETIR) ? T_RETARDO : T_REPETIR;
    localparam int T_MAX   = (T_MAX_A > T_ACK_MAX) ? T_MAX_A : T_ACK_MAX;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] C_RETARDO = TIMER_W'(T_RETARDO);
    localparam logic [TIMER_W-1:0] C_REPETIR = TIMER_W'(T_REPETIR);
    localparam logic [TIMER_W-1:0] C_ACK_MAX = TIMER_W'(T_ACK_MAX);
    localparam logic [3:0]         C_ULTIMO  = 4'(NUM_CAMPOS);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        EDICION   = 2'd1,
        REPITE    = 2'd2,
        ESCRITURA = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic [3:0]           campo_q,   campo_d;
    logic                 arriba_q,  arriba_d;
    logic                 abajo_q,   abajo_d;
    logic                 en_prog_q, en_prog_d;
    logic                 wr_req_q,  wr_req_d;
    logic                 err_ack_q, err_ack_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic [4:0]           prev_q,    prev_d;
    logic                 armed_q,   armed_d;
    logic                 dir_q,     dir_d;

    logic [4:0]           btn_now;
    logic [4:0]           pressed;
    logic                 held;

    // Button vector order: {prog, izq, der, arr, abj}
    always_comb begin
        btn_now   = {bus.btn_prog, bus.btn_izq, bus.btn_der, bus.btn_arr, bus.btn_abj};
        // armed_q is low only on the first cycle after reset, so a button held
        // through reset never looks like a fresh press.
        pressed   = btn_now & ~prev_q & {5{armed_q}};
        held      = dir_q ? bus.btn_abj : bus.btn_arr;

        prev_d    = btn_now;
        armed_d   = 1'b1;
        state_d   = state_q;
        campo_d   = campo_q;
        arriba_d  = 1'b0;
        abajo_d   = 1'b0;
        wr_req_d  = wr_req_q;
        err_ack_d = 1'b0;
        timer_d   = timer_q;
        dir_d     = dir_q;

        case (state_q)
            REPOSO: begin
                if (pressed[4]) begin
                    state_d = EDICION;
                    campo_d = 4'd1;
                end
            end
            EDICION: begin
                if (pressed[4]) begin
                    state_d  = ESCRITURA;
                    campo_d  = 4'd0;
                    wr_req_d = 1'b1;
                    timer_d  = C_ACK_MAX;
                end else if (pressed[2]) begin
                    campo_d = (campo_q >= C_ULTIMO) ? 4'd1 : campo_q + 4'd1;
                end else if (pressed[3]) begin
                    campo_d = (campo_q <= 4'd1) ? C_ULTIMO : campo_q - 4'd1;
                end else if (pressed[1] && !pressed[0]) begin
                    state_d  = REPITE;
                    arriba_d = 1'b1;
                    dir_d    = 1'b0;
                    timer_d  = C_RETARDO;
                end else if (pressed[0] && !pressed[1]) begin
                    state_d  = REPITE;
                    abajo_d  = 1'b1;
                    dir_d    = 1'b1;
                    timer_d  = C_RETARDO;
                end
            end
            REPITE: begin
                if (!held) begin
                    state_d = EDICION;
                end else if (timer_q <= TIMER_W'(1)) begin
                    // Timer reaching zero on this decrement fires the repeat.
                    arriba_d = ~dir_q;
                    abajo_d  = dir_q;
                    timer_d  = C_REPETIR;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ESCRITURA: begin
                if (bus.wr_ack) begin
                    state_d  = REPOSO;
                    wr_req_d = 1'b0;
                end else if (timer_q <= TIMER_W'(1)) begin
                    state_d   = REPOSO;
                    wr_req_d  = 1'b0;
                    err_ack_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d  = REPOSO;
                campo_d  = 4'd0;
                wr_req_d = 1'b0;
            end
        endcase

        en_prog_d = (state_d == EDICION) || (state_d == REPITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= REPOSO;
            campo_q   <= 4'd0;
            arriba_q  <= 1'b0;
            abajo_q   <= 1'b0;
            en_prog_q <= 1'b0;
            wr_req_q  <= 1'b0;
            err_ack_q <= 1'b0;
            timer_q   <= '0;
            prev_q    <= 5'd0;
            armed_q   <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            campo_q   <= campo_d;
            arriba_q  <= arriba_d;
            abajo_q   <= abajo_d;
            en_prog_q <= en_prog_d;
            wr_req_q  <= wr_req_d;
            err_ack_q <= err_ack_d;
            timer_q   <= timer_d;
            prev_q    <= prev_d;
            armed_q   <= armed_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.contadoresH = campo_q;
    assign bus.Arriba      = arriba_q;
    assign bus.Abajo       = abajo_q;
    assign bus.en_prog     = en_prog_q;
    assign bus.wr_req      = wr_req_q;
    assign bus.err_ack     = err_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_control_edicion_campos.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_edicion_campos
// Description : Directed self-checking bench for control_edicion_campos.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_edicion_campos;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    control_edicion_campos_if bus ();

    control_edicion_campos #(
        .NUM_CAMPOS (9),
        .T_RETARDO  (8),
        .T_REPETIR  (4),
        .T_ACK_MAX  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cnt"},  32'(bus.contadoresH), 32'd0);
        check({tag, "_arr"},  32'(bus.Arriba),      32'd0);
        check({tag, "_abj"},  32'(bus.Abajo),       32'd0);
        check({tag, "_en"},   32'(bus.en_prog),     32'd0);
        check({tag, "_wr"},   32'(bus.wr_req),      32'd0);
        check({tag, "_err"},  32'(bus.err_ack),     32'd0);
    endtask

    task automatic tap_der();
        bus.btn_der = 1'b1; tick();
        bus.btn_der = 1'b0; tick();
    endtask

    task automatic tap_prog();
        bus.btn_prog = 1'b1; tick();
        bus.btn_prog = 1'b0; tick();
    endtask

    initial begin
        bus.btn_prog = 1'b0; bus.btn_izq = 1'b0; bus.btn_der = 1'b0;
        bus.btn_arr  = 1'b0; bus.btn_abj = 1'b0; bus.wr_ack  = 1'b0;
        tick(); tick();
        check_idle("reset");
        reset = 1'b0;
        tick(); tick();
        check_idle("post_reset");

        // Enter edit mode and walk the field index across both wraps
        bus.btn_prog = 1'b1; tick();
        check("enter_en",  32'(bus.en_prog),     32'd1);
        check("enter_cnt", 32'(bus.contadoresH), 32'd1);
        bus.btn_prog = 1'b0; tick();
        bus.btn_izq = 1'b1; tick();
        check("izq_wrap", 32'(bus.contadoresH), 32'd9);
        bus.btn_izq = 1'b0; tick();
        tap_der();
        check("der_wrap", 32'(bus.contadoresH), 32'd1);
        tap_der();
        check("der_2", 32'(bus.contadoresH), 32'd2);
        for (int i = 0; i < 4; i++) tap_der();
        check("der_6", 32'(bus.contadoresH), 32'd6);

        // Single step: arr held 3 cycles gives one pulse
        bus.btn_arr = 1'b1; tick();
        check("step_arr", 32'(bus.Arriba), 32'd1);
        check("step_abj", 32'(bus.Abajo),  32'd0);
        tick();
        check("step_arr_off1", 32'(bus.Arriba), 32'd0);
        tick();
        check("step_arr_off2", 32'(bus.Arriba), 32'd0);
        bus.btn_arr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("step_arr_rel", 32'(bus.Arriba), 32'd0);
        end
        check("step_en", 32'(bus.en_prog), 32'd1);

        // Auto-repeat: abj held 20 cycles -> pulses at +1, +9, +13, +17
        bus.btn_abj = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("rep_abj", 32'(bus.Abajo),
                  32'((i == 1) || (i == 9) || (i == 13) || (i == 17)));
            check("rep_arr", 32'(bus.Arriba), 32'd0);
        end
        bus.btn_abj = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rep_rel_abj", 32'(bus.Abajo), 32'd0);
        end
        check("rep_cnt", 32'(bus.contadoresH), 32'd6);
        tap_der();
        check("rep_back_edicion", 32'(bus.contadoresH), 32'd7);

        // Conflicts
        bus.btn_arr = 1'b1; bus.btn_abj = 1'b1; tick();
        check("both_arr", 32'(bus.Arriba), 32'd0);
        check("both_abj", 32'(bus.Abajo),  32'd0);
        tick();
        check("both_arr2", 32'(bus.Arriba), 32'd0);
        bus.btn_arr = 1'b0; bus.btn_abj = 1'b0; tick();
        bus.btn_der = 1'b1; bus.btn_arr = 1'b1; tick();
        check("der_arr_cnt", 32'(bus.contadoresH), 32'd8);
        check("der_arr_arr", 32'(bus.Arriba),      32'd0);
        tick();
        check("der_arr_arr2", 32'(bus.Arriba), 32'd0);
        bus.btn_der = 1'b0; bus.btn_arr = 1'b0; tick();

        // Commit acknowledged
        bus.btn_prog = 1'b1; tick();
        check("commit_cnt", 32'(bus.contadoresH), 32'd0);
        check("commit_wr",  32'(bus.wr_req),      32'd1);
        check("commit_en",  32'(bus.en_prog),     32'd0);
        bus.btn_prog = 1'b0; tick(); tick();
        check("commit_wr_hold", 32'(bus.wr_req), 32'd1);
        bus.wr_ack = 1'b1; tick();
        bus.wr_ack = 1'b0;
        check("ack_wr",  32'(bus.wr_req),  32'd0);
        check("ack_err", 32'(bus.err_ack), 32'd0);
        tap_der();
        check_idle("reposo_ignores_der");
        bus.wr_ack = 1'b1; tick();
        bus.wr_ack = 1'b0; tick();
        check_idle("reposo_ignores_ack");

        // Commit timeout
        tap_prog();
        check("reenter_cnt", 32'(bus.contadoresH), 32'd1);
        bus.btn_prog = 1'b1; tick();
        bus.btn_prog = 1'b0;
        check("to_wr", 32'(bus.wr_req), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("to_wr_seq",  32'(bus.wr_req),  32'(i < 6));
            check("to_err_seq", 32'(bus.err_ack), 32'(i == 6));
        end

        // Reset during REPITE
        tap_prog();
        bus.btn_arr = 1'b1; tick();
        check("pre_rst_arr", 32'(bus.Arriba), 32'd1);
        tick(); tick();
        reset = 1'b1; #1;
        check_idle("rst_repite");
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rst_held_arr", 32'(bus.Arriba),  32'd0);
            check("rst_held_en",  32'(bus.en_prog), 32'd0);
        end
        bus.btn_arr = 1'b0; tick();

        // Reset during ESCRITURA, prog held through reset
        tap_prog();
        bus.btn_prog = 1'b1; tick();
        check("esc_wr", 32'(bus.wr_req), 32'd1);
        tick();
        reset = 1'b1; #1;
        check_idle("rst_escritura");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_held_prog_en", 32'(bus.en_prog), 32'd0);
            check("rst_held_prog_wr", 32'(bus.wr_req),  32'd0);
        end
        bus.btn_prog = 1'b0; tick();
        bus.btn_prog = 1'b1; tick();
        check("repress_en",  32'(bus.en_prog),     32'd1);
        check("repress_cnt", 32'(bus.contadoresH), 32'd1);
        bus.btn_prog = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
